// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-FU 2-entry result FIFOs, round-robin grant among FUs not
// blocked by WAR, single registered register-file write port with valid/ready.
module writeback_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5,
    parameter int FU_BITS    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  logic [NUM_FU*REG_BITS-1:0]     fu_reg,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU-1:0]              war_block,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [REG_BITS-1:0]            wb_addr,
    output logic [DATA_WIDTH-1:0]          wb_data,
    output logic [FU_BITS-1:0]             wb_fu,
    output logic [NUM_FU-1:0]              wr_done,
    output logic [NUM_FU-1:0]              overflow
);

    logic [REG_BITS-1:0]   head_reg  [NUM_FU];
    logic [DATA_WIDTH-1:0] head_data [NUM_FU];
    logic [REG_BITS-1:0]   tail_reg  [NUM_FU];
    logic [DATA_WIDTH-1:0] tail_data [NUM_FU];
    logic [1:0]            count     [NUM_FU];

    logic [FU_BITS-1:0] rr_ptr;
    logic [FU_BITS-1:0] grant;
    logic [FU_BITS-1:0] idx;
    logic               grant_any;
    logic               stage_free;
    logic [NUM_FU-1:0]  elig;
    logic [NUM_FU-1:0]  pop;

    assign stage_free = !wb_valid || wb_ready;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        idx       = '0;
        pop       = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            elig[i]     = (count[i] != 2'd0) && !war_block[i];
            fu_ready[i] = (count[i] != 2'd2);
        end
        for (int k = 0; k < NUM_FU; k++) begin
            idx = FU_BITS'((int'(rr_ptr) + k) % NUM_FU);
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant     = idx;
            end
        end
        if (stage_free && grant_any) begin
            pop[grant] = 1'b1;
        end
    end

    // FIFO occupancy and sticky overflow; a push into a full FIFO is only lost when nothing pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i] <= 2'd0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && !pop[i]) begin
                    if (count[i] == 2'd2) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        count[i] <= count[i] + 2'd1;
                    end
                end else if (!fu_valid[i] && pop[i]) begin
                    count[i] <= count[i] - 2'd1;
                end
            end
        end
    end

    // NOTE: FIFO payload storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && (count[i] == 2'd0 || (count[i] == 2'd1 && pop[i]))) begin
                head_reg[i]  <= fu_reg[i*REG_BITS +: REG_BITS];
                head_data[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (pop[i]) begin
                head_reg[i]  <= tail_reg[i];
                head_data[i] <= tail_data[i];
            end
            if (fu_valid[i] && ((count[i] == 2'd1 && !pop[i]) || (count[i] == 2'd2 && pop[i]))) begin
                tail_reg[i]  <= fu_reg[i*REG_BITS +: REG_BITS];
                tail_data[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output stage, round-robin pointer and write-complete pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_fu    <= '0;
            wr_done  <= '0;
            rr_ptr   <= '0;
        end else begin
            wr_done <= '0;
            if (wb_valid && wb_ready) begin
                wr_done[wb_fu] <= 1'b1;
            end
            if (stage_free) begin
                wb_valid <= grant_any;
                if (grant_any) begin
                    wb_addr <= head_reg[grant];
                    wb_data <= head_data[grant];
                    wb_fu   <= grant;
                    rr_ptr  <= FU_BITS'((int'(grant) + 1) % NUM_FU);
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every transfer and the following wr_done pulse.
module tb_writeback_arbiter;

    localparam int NUM_FU = 4;
    localparam int DW     = 32;
    localparam int RB     = 5;
    localparam int FB     = 2;

    typedef struct packed {
        logic [FB-1:0] fu;
        logic [RB-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_FU-1:0]    fu_valid;
    logic [NUM_FU*RB-1:0] fu_reg;
    logic [NUM_FU*DW-1:0] fu_data;
    logic [NUM_FU-1:0]    fu_ready;
    logic [NUM_FU-1:0]    war_block;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [RB-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic [FB-1:0]        wb_fu;
    logic [NUM_FU-1:0]    wr_done;
    logic [NUM_FU-1:0]    overflow;

    writeback_arbiter #(
        .NUM_FU(NUM_FU), .DATA_WIDTH(DW), .REG_BITS(RB), .FU_BITS(FB)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_valid(fu_valid), .fu_reg(fu_reg), .fu_data(fu_data), .fu_ready(fu_ready),
        .war_block(war_block),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_fu(wb_fu), .wr_done(wr_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    wb_t               exp_q[$];
    wb_t               mon_e;
    logic [NUM_FU-1:0] pending_done = '0;
    int                checks = 0;
    int                failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares each accepted write with the scoreboard head, then the wr_done a cycle later.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pending_done = '0;
        end else begin
            if (wr_done != '0 || pending_done != '0)
                check("wr_done", 64'(wr_done), 64'(pending_done));
            pending_done = '0;
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(wb_fu), 64'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_fu", 64'(wb_fu), 64'(mon_e.fu));
                    check("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
                    check("wb_data", 64'(wb_data), 64'(mon_e.data));
                    pending_done = NUM_FU'(1) << mon_e.fu;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_fu(input int fu, input logic [RB-1:0] r, input logic [DW-1:0] d);
        fu_valid[fu]         = 1'b1;
        fu_reg[fu*RB +: RB]  = r;
        fu_data[fu*DW +: DW] = d;
    endtask

    task automatic expect_wb(input int fu, input logic [RB-1:0] r, input logic [DW-1:0] d);
        wb_t e;
        e.fu   = FB'(fu);
        e.addr = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pending_done != '0) && n < 100) begin
            step();
            n++;
        end
        check(name, 64'(exp_q.size() == 0 && pending_done == '0), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        fu_valid  = '0;
        fu_reg    = '0;
        fu_data   = '0;
        war_block = '0;
        wb_ready  = 1'b1;
        step(2);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_fu_ready", 64'(fu_ready), 64'hF);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_wr_done", 64'(wr_done), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_wb_fu", 64'(wb_fu), 64'd0);

        // Single result: two-cycle latency to wb_valid
        step();
        set_fu(1, 5'd3, 32'hDEADBEEF);
        expect_wb(1, 5'd3, 32'hDEADBEEF);
        step();
        fu_valid = '0;
        @(negedge clk);
        check("single_lat1_valid", 64'(wb_valid), 64'd0);
        step();
        @(negedge clk);
        check("single_lat2_valid", 64'(wb_valid), 64'd1);
        check("single_lat2_fu", 64'(wb_fu), 64'd1);
        drain("single_drain");

        // Round-robin from rr_ptr=0
        do_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            set_fu(i, RB'(i + 4), 32'hA000_0000 + DW'(i));
            expect_wb(i, RB'(i + 4), 32'hA000_0000 + DW'(i));
        end
        step();
        fu_valid = '0;
        drain("rr_burst1");
        set_fu(0, 5'd1, 32'h0000_0B00);
        set_fu(3, 5'd2, 32'h0000_0B03);
        expect_wb(0, 5'd1, 32'h0000_0B00);
        expect_wb(3, 5'd2, 32'h0000_0B03);
        step();
        fu_valid = '0;
        drain("rr_burst2");
        // FU1 alone leaves rr_ptr=2, so a joint FU0/FU3 burst is served FU3 first
        set_fu(1, 5'd7, 32'h0000_0C01);
        expect_wb(1, 5'd7, 32'h0000_0C01);
        step();
        fu_valid = '0;
        drain("rr_single");
        set_fu(0, 5'd8, 32'h0000_0D00);
        set_fu(3, 5'd9, 32'h0000_0D03);
        expect_wb(3, 5'd9, 32'h0000_0D03);
        expect_wb(0, 5'd8, 32'h0000_0D00);
        step();
        fu_valid = '0;
        drain("rr_burst3");

        // WAR stall on FU2 while FU0 proceeds
        war_block = 4'b0100;
        set_fu(2, 5'd12, 32'h2222_0002);
        set_fu(0, 5'd13, 32'h0000_0FF0);
        expect_wb(0, 5'd13, 32'h0000_0FF0);
        expect_wb(2, 5'd12, 32'h2222_0002);
        step();
        fu_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("war_hold", 64'((wb_valid && wb_fu == 2'd2) || wr_done[2]), 64'd0);
            step();
        end
        war_block = '0;
        drain("war_drain");

        // Backpressure: held result stays stable
        wb_ready = 1'b0;
        set_fu(1, 5'd9, 32'h1234_5678);
        expect_wb(1, 5'd9, 32'h1234_5678);
        step();
        fu_valid = '0;
        step();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_valid", 64'(wb_valid), 64'd1);
            check("bp_addr", 64'(wb_addr), 64'd9);
            check("bp_data", 64'(wb_data), 64'h1234_5678);
            step();
        end
        wb_ready = 1'b1;
        drain("bp_drain");

        // Overflow on FU3 with the output stage occupied
        wb_ready = 1'b0;
        set_fu(0, 5'd7, 32'h0000_A0A0);
        expect_wb(0, 5'd7, 32'h0000_A0A0);
        step();
        fu_valid = '0;
        step();
        set_fu(3, 5'd10, 32'h0000_1111);
        expect_wb(3, 5'd10, 32'h0000_1111);
        step();
        set_fu(3, 5'd11, 32'h0000_2222);
        expect_wb(3, 5'd11, 32'h0000_2222);
        @(negedge clk);
        check("ovf_ready_after1", 64'(fu_ready[3]), 64'd1);
        step();
        set_fu(3, 5'd12, 32'h0000_3333);
        @(negedge clk);
        check("ovf_ready_after2", 64'(fu_ready[3]), 64'd0);
        check("ovf_clear_after2", 64'(overflow), 64'd0);
        step();
        fu_valid = '0;
        @(negedge clk);
        check("ovf_set_after3", 64'(overflow), 64'h8);
        step();
        wb_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_sticky", 64'(overflow), 64'h8);

        // Reset mid-operation discards held and queued results
        wb_ready = 1'b0;
        set_fu(1, 5'd14, 32'h0000_5151);
        set_fu(2, 5'd15, 32'h0000_5252);
        step();
        fu_valid = '0;
        step();
        @(negedge clk);
        check("midrst_pre_valid", 64'(wb_valid), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wb_valid", 64'(wb_valid), 64'd0);
        check("midrst_fu_ready", 64'(fu_ready), 64'hF);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_wr_done", 64'(wr_done), 64'd0);
        step();
        wb_ready = 1'b1;
        step(4);
        set_fu(2, 5'd20, 32'h0000_CAFE);
        expect_wb(2, 5'd20, 32'h0000_CAFE);
        step();
        fu_valid = '0;
        drain("post_rst_drain");

        step(2);
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Consumer end of the functional-unit result interface in the scoreboard datapath.
- Captures one-cycle result pulses (valid/reg/data) from NUM_FU functional units into per-FU 2-entry FIFOs.
- Arbitrates round-robin among FUs not blocked by the scoreboard's WAR check, and drives the single register-file write port with a valid/ready handshake.
- Returns a per-FU write-complete pulse so the scoreboard can release FU status.

Parameters:
- NUM_FU, 4, number of functional units (2..8)
- DATA_WIDTH, 32, result data width
- REG_BITS, 5, destination register index width
- FU_BITS, 2, width of FU index (>= clog2(NUM_FU))

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- fu_valid  input  NUM_FU  per-FU result pulse, one cycle per result
- fu_reg  input  NUM_FU*REG_BITS  per-FU destination register, slice i = [i*REG_BITS +: REG_BITS]
- fu_data  input  NUM_FU*DATA_WIDTH  per-FU result data, slice i likewise
- fu_ready  output  NUM_FU  FIFO i not full (advisory; FUs have no stall)
- war_block  input  NUM_FU  scoreboard: FU i must not write yet (pending reader of its Fi)
- wb_valid  output  1  write port request
- wb_ready  input  1  register file accepts write
- wb_addr  output  REG_BITS  write register index
- wb_data  output  DATA_WIDTH  write data
- wb_fu  output  FU_BITS  index of FU owning current write
- wr_done  output  NUM_FU  one-cycle pulse, FU i's write completed
- overflow  output  NUM_FU  sticky: result from FU i dropped

Behaviour:
- Reset (rst=1 at edge): all FIFOs empty, fu_ready all 1, wb_valid=0, wb_addr=0, wb_data=0, wb_fu=0, wr_done=0, overflow=0, rr_ptr=0. Reset mid-transfer discards held and queued results; no wr_done is issued for them.
- FIFO i, depth 2:
  - push at edge when fu_valid[i]; pop when granted; count in 0..2.
  - Push and pop in the same cycle: both happen, count unchanged; allowed even when full.
  - Push when count=2 without pop: data dropped, overflow[i] set (cleared only by rst).
  - Push when count=1 with pop: the new entry becomes the head next cycle.
  - fu_ready[i] = (count != 2).
- Eligibility: elig[i] = FIFO i non-empty AND !war_block[i]. war_block is sampled combinationally in the arbitration cycle.
- Output stage: single register (wb_valid/addr/data/fu). It is free when wb_valid=0 or (wb_valid && wb_ready).
- Arbitration, each cycle the output stage is free and any elig:
  - Grant the first elig index searching rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Pop that FIFO head into the output stage at the edge.
  - Update rr_ptr = (grant+1) mod NUM_FU.
  - If no elig: rr_ptr unchanged; wb_valid clears if the prior transfer completed.
- Handshake:
  - wb_valid, wb_addr, wb_data and wb_fu are held stable while wb_valid && !wb_ready.
  - Transfer occurs at an edge with wb_valid && wb_ready.
  - A back-to-back transfer each cycle is possible when wb_ready stays high.
- wr_done[wb_fu] pulses in the cycle after the transfer edge (registered), one pulse per transfer.
- Latency: fu_valid in cycle t gives the FIFO entry at t+1. With the output stage free and elig, wb_valid=1 at t+2. Minimum latency is 2 cycles.
- war_block rising while a result sits in the output stage has no effect; the result is already committed.
- Ordering: per-FU results are written in arrival order. No ordering is guaranteed across FUs beyond round-robin.
- Data is passed unmodified. No arithmetic beyond index modulo NUM_FU.

Test Plan:
- Single result: fu_valid[1] at cycle 5, reg=3, data=0xDEADBEEF, wb_ready=1 → wb_valid at cycle 7 with addr=3, data=0xDEADBEEF, fu=1; wr_done=0b0010 at cycle 8.
- Round-robin: FUs 0,1,2,3 pulse together at cycle 2, wb_ready=1 → writes at cycles 4,5,6,7 in order fu=0,1,2,3. A second burst from FUs 0 and 3 after rr_ptr=0 is served as fu 0 then fu 3.
- WAR stall: FU 2 result queued with war_block[2]=1 for 5 cycles while FU 0 has a result → FU 0 is written first; FU 2 is written 2 cycles after war_block drops, with no wr_done[2] before then.
- Backpressure: wb_ready=0 for 4 cycles with a result held → wb_addr/data stable, wb_valid=1 throughout; a single write and single wr_done occur after wb_ready=1.
- Overflow: wb_ready=0 and FU 3 pulses 3 times on consecutive cycles → fu_ready[3]=0 after the 2nd; overflow[3]=1 after the 3rd; the first two results are written in order once wb_ready=1.
- Reset mid-operation: rst=1 while wb_valid=1 and FIFOs hold entries → next cycle wb_valid=0, fu_ready=all 1, overflow=0, no wr_done pulses; the next fu_valid is written normally.
